// File: rtl/urv_mem_arb_pkg.sv
// urv_mem_arb_pkg: shared encodings for the uRV I/D memory arbiter.
package urv_mem_arb_pkg;
  localparam int STARVE_W = 4;
  typedef enum logic [1:0] {
    GNT_NONE   = 2'd0,
    GNT_I      = 2'd1,
    GNT_DLOAD  = 2'd2,
    GNT_DSTORE = 2'd3
  } gnt_e;
endpackage

// File: rtl/urv_mem_arbiter.sv
// urv_mem_arbiter: D-priority arbiter for one registered-read RAM shared by fetch and load/store.
// Optional stall statistics counter enabled by URV_MEM_ARB_STATS_EN.
module urv_mem_arbiter
  import urv_mem_arb_pkg::*;
#(
  parameter int g_d_burst_max = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        im_rd_i,
  input  logic [31:0] im_addr_i,
  output logic        im_gnt_o,
  output logic [31:0] im_data_o,
  output logic        im_valid_o,
  input  logic        dm_load_i,
  input  logic        dm_store_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  output logic        dm_gnt_o,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_we_o,
  input  logic [31:0] mem_rdata_i
`ifdef URV_MEM_ARB_STATS_EN
  ,
  input  logic        stat_clr_i,
  output logic [31:0] stat_i_stall_o
`endif
);
  localparam logic [STARVE_W-1:0] BURST_MAX = STARVE_W'(g_d_burst_max);
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  gnt_e last_gnt_q, last_gnt_d;
  logic d_req, gnt_d, gnt_i;
  always_comb begin
    d_req = dm_load_i | dm_store_i;
    gnt_d = !rst_i && d_req && (!im_rd_i || starve_cnt_q < BURST_MAX);
    gnt_i = !rst_i && im_rd_i && !gnt_d;
    starve_cnt_d = (!im_rd_i || gnt_i) ? '0 :
                   (gnt_d && starve_cnt_q < BURST_MAX) ? starve_cnt_q + 1'b1 : starve_cnt_q;
    last_gnt_d = gnt_i ? GNT_I : !gnt_d ? GNT_NONE : dm_load_i ? GNT_DLOAD : GNT_DSTORE;
  end
  assign im_gnt_o        = gnt_i;
  assign dm_gnt_o        = gnt_d;
  assign mem_addr_o      = gnt_d ? dm_addr_i : im_addr_i;
  assign mem_wdata_o     = dm_data_s_i;
  assign mem_we_o        = (gnt_d && !dm_load_i) ? dm_data_select_i : 4'b0;
  assign im_data_o       = mem_rdata_i;
  assign dm_data_l_o     = mem_rdata_i;
  assign im_valid_o      = last_gnt_q == GNT_I;
  assign dm_load_done_o  = last_gnt_q == GNT_DLOAD;
  assign dm_store_done_o = last_gnt_q == GNT_DSTORE;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_cnt_q <= '0;
      last_gnt_q   <= GNT_NONE;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      last_gnt_q   <= last_gnt_d;
    end
  end
`ifdef URV_MEM_ARB_STATS_EN
  logic [31:0] stall_q, stall_d;
  always_comb stall_d = stat_clr_i ? 32'd0 : stall_q + {31'd0, im_rd_i & !gnt_i};
  always_ff @(posedge clk_i) begin
    if (rst_i) stall_q <= '0;
    else stall_q <= stall_d;
  end
  assign stat_i_stall_o = stall_q;
`endif
endmodule

// File: tb/tb_urv_mem_arbiter.sv
// tb_urv_mem_arbiter: directed and random checks of urv_mem_arbiter against a transaction-level model.
module tb_urv_mem_arbiter;
  localparam int BURST = 4;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        im_rd_i, im_gnt_o, im_valid_o;
  logic [31:0] im_addr_i, im_data_o;
  logic        dm_load_i, dm_store_i, dm_gnt_o, dm_load_done_o, dm_store_done_o;
  logic [31:0] dm_addr_i, dm_data_s_i, dm_data_l_o;
  logic [3:0]  dm_data_select_i, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
`ifdef URV_MEM_ARB_STATS_EN
  logic        stat_clr_i;
  logic [31:0] stat_i_stall_o;
  int          exp_stall;
`endif
  int          n_tests = 0, n_fail = 0;
  int          m_wait, exp_last;
  logic [31:0] exp_data;
  logic [31:0] ram [256];
  logic [31:0] ref_mem [256];
  logic        last_gi, last_gd;
  logic [9:0]  seq;

  urv_mem_arbiter #(.g_d_burst_max(BURST)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .im_rd_i(im_rd_i), .im_addr_i(im_addr_i), .im_gnt_o(im_gnt_o),
    .im_data_o(im_data_o), .im_valid_o(im_valid_o),
    .dm_load_i(dm_load_i), .dm_store_i(dm_store_i), .dm_addr_i(dm_addr_i),
    .dm_data_s_i(dm_data_s_i), .dm_data_select_i(dm_data_select_i),
    .dm_gnt_o(dm_gnt_o), .dm_data_l_o(dm_data_l_o),
    .dm_load_done_o(dm_load_done_o), .dm_store_done_o(dm_store_done_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o),
    .mem_rdata_i(mem_rdata_i)
`ifdef URV_MEM_ARB_STATS_EN
    , .stat_clr_i(stat_clr_i), .stat_i_stall_o(stat_i_stall_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Write-first single-port RAM with one cycle read latency.
  always @(posedge clk_i) begin
    logic [31:0] w;
    w = ram[mem_addr_o[9:2]];
    for (int b = 0; b < 4; b++) if (mem_we_o[b]) w[8*b+:8] = mem_wdata_o[8*b+:8];
    ram[mem_addr_o[9:2]] = w;
    mem_rdata_i <= w;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic ld, input logic st,
                       input logic [31:0] da, input logic [31:0] dd, input logic [3:0] sel);
    im_rd_i = ir; im_addr_i = ia; dm_load_i = ld; dm_store_i = st;
    dm_addr_i = da; dm_data_s_i = dd; dm_data_select_i = sel;
  endtask

  // Entered 1 time unit after a rising edge with inputs applied; leaves at the same phase.
  task automatic cycle();
    logic gd, gi;
    logic [31:0] w;
    #3;
    gd = !rst_i && (dm_load_i || dm_store_i) && (!im_rd_i || m_wait < BURST);
    gi = !rst_i && im_rd_i && !gd;
    chk("dm_gnt", {31'd0, dm_gnt_o}, {31'd0, gd});
    chk("im_gnt", {31'd0, im_gnt_o}, {31'd0, gi});
    chk("mem_we", {28'd0, mem_we_o}, (gd && !dm_load_i) ? {28'd0, dm_data_select_i} : 32'd0);
    if (gd) chk("addr_d", mem_addr_o, dm_addr_i);
    else if (gi) chk("addr_i", mem_addr_o, im_addr_i);
    chk("im_valid", {31'd0, im_valid_o}, {31'd0, exp_last == 1});
    chk("ld_done", {31'd0, dm_load_done_o}, {31'd0, exp_last == 2});
    chk("st_done", {31'd0, dm_store_done_o}, {31'd0, exp_last == 3});
    if (exp_last == 1) chk("im_data", im_data_o, exp_data);
    if (exp_last == 2) chk("dm_data", dm_data_l_o, exp_data);
`ifdef URV_MEM_ARB_STATS_EN
    chk("stall", stat_i_stall_o, exp_stall);
`endif
    last_gi = gi;
    last_gd = gd;
    @(posedge clk_i);
    if (rst_i) begin
      m_wait = 0; exp_last = 0;
`ifdef URV_MEM_ARB_STATS_EN
      exp_stall = 0;
`endif
    end else begin
`ifdef URV_MEM_ARB_STATS_EN
      exp_stall = stat_clr_i ? 0 : exp_stall + int'(im_rd_i && !gi);
`endif
      exp_last = gi ? 1 : !gd ? 0 : dm_load_i ? 2 : 3;
      if (gi) exp_data = ref_mem[im_addr_i[9:2]];
      if (gd && dm_load_i) exp_data = ref_mem[dm_addr_i[9:2]];
      if (gd && !dm_load_i) begin
        w = ref_mem[dm_addr_i[9:2]];
        for (int b = 0; b < 4; b++) if (dm_data_select_i[b]) w[8*b+:8] = dm_data_s_i[8*b+:8];
        ref_mem[dm_addr_i[9:2]] = w;
      end
      // Count D grants in a row while fetch is kept waiting.
      m_wait = (!im_rd_i || gi) ? 0 : gd ? m_wait + 1 : m_wait;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = (i < 3) ? i : 32'h1234_0000 + i;
      ref_mem[i] = ram[i];
    end
    m_wait = 0; exp_last = 0; exp_data = 0;
`ifdef URV_MEM_ARB_STATS_EN
    exp_stall = 0; stat_clr_i = 1'b0;
`endif
    rst_i = 1'b1;
    drive(1, 0, 1, 0, 32'h40, 0, 0);
    @(posedge clk_i); #1;
    cycle();
    drive(0, 0, 0, 1, 32'h40, 32'hFFFF_FFFF, 4'hF);
    cycle();
    rst_i = 1'b0;
    drive(1, 32'h0, 0, 0, 0, 0, 0); cycle();
    drive(1, 32'h4, 0, 0, 0, 0, 0); cycle();
    drive(1, 32'h8, 0, 0, 0, 0, 0); cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    #2 chk("fetch_w2", im_data_o, 32'd2);
    cycle();
    drive(1, 32'hC, 1, 0, 32'h100, 0, 0); cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    #2 chk("load_w40", dm_data_l_o, 32'h1234_0040);
    cycle();
    drive(1, 32'h10, 1, 0, 32'h104, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cycle();
      seq[i] = last_gd;
    end
    chk("burst_seq", {22'd0, seq}, 32'b01_1110_1111);
    drive(0, 0, 0, 1, 32'h20, 32'hDEAD_BEEF, 4'b0011); cycle();
    drive(0, 0, 1, 0, 32'h20, 0, 0); cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    #2 chk("merge", dm_data_l_o, 32'h1234_BEEF);
    cycle();
    drive(0, 0, 1, 0, 32'h44, 0, 0); cycle();
    rst_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0); cycle();
    rst_i = 1'b0;
    cycle();
    chk("rst_starve", {28'd0, dut.starve_cnt_q}, 32'd0);
    for (int i = 0; i < 400; i++) begin
      if (!im_rd_i || last_gi) begin
        im_rd_i = $urandom_range(0, 3) != 0;
        im_addr_i = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      end
      if (!(dm_load_i || dm_store_i) || last_gd) begin
        dm_load_i = $urandom_range(0, 2) == 0;
        dm_store_i = $urandom_range(0, 2) == 0;
        dm_addr_i = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        dm_data_s_i = $urandom;
        dm_data_select_i = 4'($urandom_range(0, 15));
      end
`ifdef URV_MEM_ARB_STATS_EN
      stat_clr_i = $urandom_range(0, 49) == 0;
`endif
      cycle();
    end
`ifdef URV_MEM_ARB_STATS_EN
    stat_clr_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0); cycle();
    stat_clr_i = 1'b0;
    #2 chk("stall_clr", stat_i_stall_o, 32'd0);
    cycle();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/urv_mem_arbiter.md
Name: urv_mem_arbiter

Overview:
- Shares one single-port, registered-read memory between the instruction fetch side (I) and the load/store side (D) of the uRV core.
- Sits between urv_fetch / load-store logic and the on-chip RAM.
- D-side has priority. A burst limit guarantees fetch progress.
- When the I-side is not granted, im_valid_o stays low, so fetch simply holds its PC.

Parameters:
- g_d_burst_max, 4: maximum consecutive D grants while an I request is waiting; legal range 1..15.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- im_rd_i  in  1  fetch read request
- im_addr_i  in  32  fetch byte address
- im_gnt_o  out  1  fetch request accepted this cycle
- im_data_o  out  32  fetch read data
- im_valid_o  out  1  im_data_o valid (cycle after im_gnt_o)
- dm_load_i  in  1  load request
- dm_store_i  in  1  store request
- dm_addr_i  in  32  load/store byte address
- dm_data_s_i  in  32  store data
- dm_data_select_i  in  4  store byte lanes
- dm_gnt_o  out  1  D request accepted this cycle
- dm_data_l_o  out  32  load data
- dm_load_done_o  out  1  load data valid (cycle after grant)
- dm_store_done_o  out  1  store completed (cycle after grant)
- mem_addr_o  out  32  RAM address (word = addr[31:2])
- mem_wdata_o  out  32  RAM write data
- mem_we_o  out  4  RAM byte write enables
- mem_rdata_i  in  32  RAM read data, 1-cycle latency

Behaviour:
- Handshake: a request is accepted when the request and its grant are both high in the same cycle. Requesters hold address/data stable until granted.
- Grants are combinational, from the current requests and the registered starvation counter.
- dm_load_i and dm_store_i both high is illegal; the load wins.
- Grant rule:
  - D request and starve_cnt < g_d_burst_max: grant D.
  - Else, I request: grant I.
  - Else, D request: grant D.
  - Else: no grant.
- At most one grant per cycle.
- mem_addr_o is the granted address: dm_addr_i when D is granted, otherwise im_addr_i.
- mem_we_o = dm_data_select_i when a store is granted, otherwise 0.
- mem_wdata_o = dm_data_s_i.
- starve_cnt (4 bit):
  - Increments when D is granted while im_rd_i is high.
  - Clears when I is granted or im_rd_i is low.
  - Saturates at g_d_burst_max.
- Registered last_gnt ∈ {NONE, I, DLOAD, DSTORE} routes the returned data:
  - im_valid_o = (last_gnt==I).
  - dm_load_done_o = (last_gnt==DLOAD).
  - dm_store_done_o = (last_gnt==DSTORE).
  - im_data_o = dm_data_l_o = mem_rdata_i, passed through without a register.
- Latency: grant at cycle N → done/valid at N+1. Throughput is one access per cycle.
- Store at N followed by a read of the same word at N+1 returns the new data; RAM write-first is guaranteed by the RAM.
- Reset:
  - last_gnt=NONE, starve_cnt=0.
  - im_valid_o, dm_load_done_o, dm_store_done_o = 0 in the cycle after rst_i.
  - Combinational outputs: all grants=0 and mem_we_o=0 while rst_i is high.
  - A reset mid-transaction discards the outstanding response; no done/valid pulse is produced for it.

Optional Feature:
- Macro URV_MEM_ARB_STATS_EN.
- Defined:
  - Adds output stat_i_stall_o [31:0], counting cycles with im_rd_i high and im_gnt_o low.
  - Adds input stat_clr_i, which clears the counter synchronously.
  - The counter wraps at 2^32 and resets to 0.
- Undefined: neither port nor the counter exists; behaviour is otherwise identical.

Decomposition:
- Package urv_mem_arb_pkg holds:
  - the last_gnt encoding: GNT_NONE=2'd0, GNT_I=2'd1, GNT_DLOAD=2'd2, GNT_DSTORE=2'd3;
  - the starve counter width constant (4).
- No sub-module. The optional statistics counter stays inline under the macro.

Test Plan:
- Only im_rd_i high, addr 0x0,0x4,0x8 on consecutive cycles → im_gnt_o=1 each cycle; im_valid_o=1 from the next cycle with RAM words 0,1,2; no D outputs.
- im_rd_i and dm_load_i high together, dm_addr 0x100 → dm_gnt_o=1, im_gnt_o=0; dm_load_done_o=1 next cycle with RAM[0x40]; im_valid_o=0 that cycle.
- im_rd_i held high, D requests every cycle, g_d_burst_max=4 → pattern of 4 D grants, 1 I grant, repeating.
- Store 0xDEADBEEF, select 4'b0011 at 0x20, then load 0x20 → mem_we_o=4'b0011 at grant; load returns the low half 0xBEEF merged with the old upper half.
- Load granted, then rst_i asserted at the next edge → dm_load_done_o=0, im_valid_o=0 after reset; starve_cnt=0.
- URV_MEM_ARB_STATS_EN defined, 10 cycles of I starved by D → stat_i_stall_o=10 (with g_d_burst_max ≥ 10 and I excluded); stat_clr_i → 0.
